// File: rtl/crc32_pkg.sv
// Shared CRC-32 definitions: reflected Ethernet polynomial, default init/xorout,
// pipeline control payload and the single-byte reflected update.
package crc32_pkg;

  localparam logic [31:0] CRC32_POLY_REFL      = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT_DEFAULT   = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOROUT_DEFAULT = 32'hFFFFFFFF;

  typedef struct packed {
    logic valid;
    logic sop;
    logic eop;
  } crc32_ctrl_t;

  // One byte through the reflected LFSR, LSB first; no init/xorout applied here.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data_byte);
    logic [31:0] c;
    c = crc ^ {24'h0, data_byte};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_word_update.sv
// Combinational CRC-32 update over the low nbytes bytes of a word, byte0 first.
module crc32_word_update
  import crc32_pkg::*;
#(
  parameter int unsigned DATA_BYTES = 8
) (
  input  logic [31:0]                       crc_in,
  input  logic [8*DATA_BYTES-1:0]           data,
  input  logic [$clog2(DATA_BYTES+1)-1:0]   nbytes,
  output logic [31:0]                       crc_out
);

  localparam int unsigned NB_W = $clog2(DATA_BYTES + 1);

  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (NB_W'(i) < nbytes) begin
        crc_out = crc32_byte(crc_out, data[8*i +: 8]);
      end
    end
  end

endmodule

// File: rtl/crc32_stream.sv
// Streaming per-packet CRC-32 with delay-matched passthrough. The word CRC is split
// into a data-only partial (stage 2) and a start-value term combined at the accumulator.
module crc32_stream
  import crc32_pkg::*;
#(
  parameter int unsigned DATA_BYTES = 8,
  parameter logic [31:0] CRC_INIT   = CRC32_INIT_DEFAULT,
  parameter logic [31:0] CRC_XOROUT = CRC32_XOROUT_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    ce,
  input  logic                    valid_in,
  input  logic                    sop_in,
  input  logic                    eop_in,
  input  logic [DATA_BYTES-1:0]   keep_in,
  input  logic [8*DATA_BYTES-1:0] data_in,
  output logic                    valid_out,
  output logic                    sop_out,
  output logic                    eop_out,
  output logic [DATA_BYTES-1:0]   keep_out,
  output logic [8*DATA_BYTES-1:0] data_out,
  output logic                    crc_valid,
  output logic [31:0]             crc
);

  localparam int unsigned DW   = 8 * DATA_BYTES;
  localparam int unsigned NB_W = $clog2(DATA_BYTES + 1);

  crc32_ctrl_t           s1_ctrl_q, s1_ctrl_d, s2_ctrl_q, s2_ctrl_d;
  crc32_ctrl_t           s3_ctrl_q, s3_ctrl_d, out_ctrl_q, out_ctrl_d;
  logic [DATA_BYTES-1:0] s1_keep_q, s1_keep_d, s2_keep_q, s2_keep_d;
  logic [DATA_BYTES-1:0] s3_keep_q, s3_keep_d, out_keep_q, out_keep_d;
  logic [DW-1:0]         s1_data_q, s1_data_d, s2_data_q, s2_data_d;
  logic [DW-1:0]         s3_data_q, s3_data_d, out_data_q, out_data_d;
  logic [NB_W-1:0]       s1_nbytes_q, s1_nbytes_d, s2_nbytes_q, s2_nbytes_d;
  logic [31:0]           s2_part_q, s2_part_d;
  logic [31:0]           acc_q, acc_d;
  logic [31:0]           s3_fcrc_q, s3_fcrc_d;
  logic                  crc_valid_q, crc_valid_d;
  logic [31:0]           crc_q, crc_d;
  logic [31:0]           part_c, start_c, shift_c, word_crc_c;

  // Length of the contiguous run of ones in keep starting at bit0.
  function automatic logic [NB_W-1:0] keep_len(input logic [DATA_BYTES-1:0] keep);
    logic [NB_W-1:0] n;
    logic            run;
    n   = '0;
    run = 1'b1;
    for (int i = 0; i < DATA_BYTES; i++) begin
      run = run & keep[i];
      n   = n + NB_W'(run);
    end
    return n;
  endfunction

  // Data-only contribution (zero start value).
  crc32_word_update #(.DATA_BYTES(DATA_BYTES)) u_part (
    .crc_in  (32'h0),
    .data    (s1_data_q),
    .nbytes  (s1_nbytes_q),
    .crc_out (part_c)
  );

  // Start-value contribution: the start value clocked through nbytes zero bytes.
  crc32_word_update #(.DATA_BYTES(DATA_BYTES)) u_shift (
    .crc_in  (start_c),
    .data    ({DW{1'b0}}),
    .nbytes  (s2_nbytes_q),
    .crc_out (shift_c)
  );

  assign start_c    = s2_ctrl_q.sop ? CRC_INIT : acc_q;
  assign word_crc_c = shift_c ^ s2_part_q;

  always_comb begin
    s1_ctrl_d.valid = valid_in;
    s1_ctrl_d.sop   = valid_in & sop_in;
    s1_ctrl_d.eop   = valid_in & eop_in;
    s1_keep_d       = keep_in;
    s1_data_d       = data_in;
    s1_nbytes_d     = eop_in ? keep_len(keep_in) : NB_W'(DATA_BYTES);

    s2_ctrl_d   = s1_ctrl_q;
    s2_keep_d   = s1_keep_q;
    s2_data_d   = s1_data_q;
    s2_nbytes_d = s1_nbytes_q;
    s2_part_d   = part_c;

    s3_ctrl_d = s2_ctrl_q;
    s3_keep_d = s2_keep_q;
    s3_data_d = s2_data_q;
    acc_d     = acc_q;
    s3_fcrc_d = s3_fcrc_q;
    if (s2_ctrl_q.valid) begin
      if (s2_ctrl_q.eop) begin
        acc_d     = CRC_INIT;
        s3_fcrc_d = word_crc_c ^ CRC_XOROUT;
      end else begin
        acc_d = word_crc_c;
      end
    end

    out_ctrl_d  = s3_ctrl_q;
    out_keep_d  = s3_keep_q;
    out_data_d  = s3_data_q;
    crc_valid_d = s3_ctrl_q.valid & s3_ctrl_q.eop;
    crc_d       = crc_valid_d ? s3_fcrc_q : crc_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_ctrl_q   <= '0;
      s2_ctrl_q   <= '0;
      s3_ctrl_q   <= '0;
      out_ctrl_q  <= '0;
      s1_keep_q   <= '0;
      s2_keep_q   <= '0;
      s3_keep_q   <= '0;
      out_keep_q  <= '0;
      s1_data_q   <= '0;
      s2_data_q   <= '0;
      s3_data_q   <= '0;
      out_data_q  <= '0;
      s1_nbytes_q <= '0;
      s2_nbytes_q <= '0;
      s2_part_q   <= '0;
      acc_q       <= CRC_INIT;
      s3_fcrc_q   <= '0;
      crc_valid_q <= 1'b0;
      crc_q       <= '0;
    end else if (ce) begin
      s1_ctrl_q   <= s1_ctrl_d;
      s2_ctrl_q   <= s2_ctrl_d;
      s3_ctrl_q   <= s3_ctrl_d;
      out_ctrl_q  <= out_ctrl_d;
      s1_keep_q   <= s1_keep_d;
      s2_keep_q   <= s2_keep_d;
      s3_keep_q   <= s3_keep_d;
      out_keep_q  <= out_keep_d;
      s1_data_q   <= s1_data_d;
      s2_data_q   <= s2_data_d;
      s3_data_q   <= s3_data_d;
      out_data_q  <= out_data_d;
      s1_nbytes_q <= s1_nbytes_d;
      s2_nbytes_q <= s2_nbytes_d;
      s2_part_q   <= s2_part_d;
      acc_q       <= acc_d;
      s3_fcrc_q   <= s3_fcrc_d;
      crc_valid_q <= crc_valid_d;
      crc_q       <= crc_d;
    end
  end

  assign valid_out = out_ctrl_q.valid;
  assign sop_out   = out_ctrl_q.sop;
  assign eop_out   = out_ctrl_q.eop;
  assign keep_out  = out_keep_q;
  assign data_out  = out_data_q;
  assign crc_valid = crc_valid_q;
  assign crc       = crc_q;

endmodule

// File: tb/tb_crc32_stream.sv
// Scoreboard bench for crc32_stream (DATA_BYTES=8): expected words queued at drive
// time, popped and compared when the delayed word emerges.
module tb_crc32_stream;

  localparam int unsigned DB = 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          ce = 1'b0;
  logic          valid_in = 1'b0;
  logic          sop_in = 1'b0;
  logic          eop_in = 1'b0;
  logic [DB-1:0] keep_in = '0;
  logic [63:0]   data_in = '0;
  logic          valid_out, sop_out, eop_out, crc_valid;
  logic [DB-1:0] keep_out;
  logic [63:0]   data_out;
  logic [31:0]   crc;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        sop;
    logic        eop;
    logic [31:0] crc;
    int          tag;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mit;
  int          checks = 0;
  int          errors = 0;
  int          ce_cnt = 0;
  logic        last_ce = 1'b0;
  logic [31:0] last_crc = 32'h0;

  crc32_stream #(.DATA_BYTES(DB)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .ce        (ce),
    .valid_in  (valid_in),
    .sop_in    (sop_in),
    .eop_in    (eop_in),
    .keep_in   (keep_in),
    .data_in   (data_in),
    .valid_out (valid_out),
    .sop_out   (sop_out),
    .eop_out   (eop_out),
    .keep_out  (keep_out),
    .data_out  (data_out),
    .crc_valid (crc_valid),
    .crc       (crc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    last_ce <= ce & rstn;
    ce_cnt  <= ce_cnt + (ce ? 1 : 0);
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] ref_crc(input logic [7:0] b[$]);
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      c = c ^ {24'h0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // Output monitor: evaluated only on cycles where the DUT registers advanced.
  always @(negedge clk) begin
    if (rstn && last_ce) begin
      if (valid_out) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: valid_out=1 data_out=%h, scoreboard empty", data_out);
        end else begin
          mit = exp_q.pop_front();
          if ({data_out, keep_out, sop_out, eop_out} !== {mit.data, mit.keep, mit.sop, mit.eop}) begin
            errors++;
            $display("FAIL passthru: got data=%h keep=%h sop=%b eop=%b, want data=%h keep=%h sop=%b eop=%b",
                     data_out, keep_out, sop_out, eop_out, mit.data, mit.keep, mit.sop, mit.eop);
          end
          checks++;
          if (ce_cnt !== mit.tag + 4) begin
            errors++;
            $display("FAIL latency: got %0d ce cycles, want 4", ce_cnt - mit.tag);
          end
          checks++;
          if (crc_valid !== mit.eop) begin
            errors++;
            $display("FAIL crc_valid: got %b want %b", crc_valid, mit.eop);
          end
          if (mit.eop) begin
            checks++;
            if (crc !== mit.crc) begin
              errors++;
              $display("FAIL crc_value: got %h want %h", crc, mit.crc);
            end
            last_crc = mit.crc;
          end
        end
      end else begin
        checks++;
        if ({sop_out, eop_out, crc_valid} !== 3'b000) begin
          errors++;
          $display("FAIL idle_flags: got sop=%b eop=%b crc_valid=%b want 000", sop_out, eop_out, crc_valid);
        end
      end
      if (!(valid_out && eop_out)) begin
        checks++;
        if (crc !== last_crc) begin
          errors++;
          $display("FAIL crc_hold: got %h want %h", crc, last_crc);
        end
      end
    end
  end

  task automatic send_word(input logic [63:0] d, input logic [7:0] k, input logic s,
                           input logic e, input logic [31:0] c, input bit push);
    exp_t it;
    @(negedge clk);
    ce = 1'b1; valid_in = 1'b1; sop_in = s; eop_in = e; keep_in = k; data_in = d;
    it.data = d; it.keep = k; it.sop = s; it.eop = e; it.crc = c; it.tag = ce_cnt;
    if (push) exp_q.push_back(it);
  endtask

  task automatic idle_cycle(input logic ce_v);
    @(negedge clk);
    ce = ce_v; valid_in = 1'b0;
    sop_in = 1'($urandom); eop_in = 1'($urandom);
    keep_in = 8'($urandom); data_in = {32'($urandom), 32'($urandom)};
  endtask

  task automatic wait_drain(output bit ok);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) idle_cycle(1'b1);
    repeat (2) idle_cycle(1'b1);
    ok = (exp_q.size() == 0);
  endtask

  task automatic test_reset_state();
    repeat (3) @(negedge clk);
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid_out: got %b want 0", valid_out); end
    checks++; if (sop_out !== 1'b0) begin errors++; $display("FAIL rst_sop_out: got %b want 0", sop_out); end
    checks++; if (eop_out !== 1'b0) begin errors++; $display("FAIL rst_eop_out: got %b want 0", eop_out); end
    checks++; if (crc_valid !== 1'b0) begin errors++; $display("FAIL rst_crc_valid: got %b want 0", crc_valid); end
    checks++; if (crc !== 32'h0) begin errors++; $display("FAIL rst_crc: got %h want 0", crc); end
    checks++; if (data_out !== 64'h0) begin errors++; $display("FAIL rst_data_out: got %h want 0", data_out); end
    checks++; if (keep_out !== 8'h0) begin errors++; $display("FAIL rst_keep_out: got %h want 0", keep_out); end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_two_word();
    bit ok;
    send_word(64'h3837363534333231, 8'hFF, 1'b1, 1'b0, 32'h0, 1'b1);
    send_word(64'hA5A5A5A5A5A5A539, 8'h01, 1'b0, 1'b1, 32'hCBF43926, 1'b1);
    wait_drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL two_word_drain: outstanding=%0d want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    send_word(64'h0000000000000061, 8'h01, 1'b1, 1'b1, 32'hE8B7BE43, 1'b1);
    send_word(64'h0000000000636261, 8'h07, 1'b1, 1'b1, 32'h352441C2, 1'b1);
    wait_drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_drain: outstanding=%0d want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_ce_stall();
    bit ok;
    send_word(64'h3837363534333231, 8'hFF, 1'b1, 1'b0, 32'h0, 1'b1);
    repeat (3) idle_cycle(1'b0);
    idle_cycle(1'b1);
    send_word(64'h0000000000000039, 8'h01, 1'b0, 1'b1, 32'hCBF43926, 1'b1);
    idle_cycle(1'b1);
    repeat (2) idle_cycle(1'b0);
    wait_drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ce_stall_drain: outstanding=%0d want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    send_word(64'h3837363534333231, 8'hFF, 1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    valid_in = 1'b0;
    rstn = 1'b0;
    last_crc = 32'h0;
    #1;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL midrst_valid_out: got %b want 0", valid_out); end
    checks++; if (crc_valid !== 1'b0) begin errors++; $display("FAIL midrst_crc_valid: got %b want 0", crc_valid); end
    checks++; if (crc !== 32'h0) begin errors++; $display("FAIL midrst_crc: got %h want 0", crc); end
    checks++; if (data_out !== 64'h0) begin errors++; $display("FAIL midrst_data_out: got %h want 0", data_out); end
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    send_word(64'h0000000000000061, 8'h01, 1'b1, 1'b1, 32'hE8B7BE43, 1'b1);
    wait_drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL midrst_drain: outstanding=%0d want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_keep_gap();
    bit ok;
    logic [7:0] b[$];
    for (int i = 0; i < 8; i++) b.push_back(8'(8'h31 + i));
    send_word(64'h0000000000633F61, 8'h05, 1'b1, 1'b1, 32'hE8B7BE43, 1'b1);
    send_word(64'h3837363534333231, 8'hFF, 1'b0, 1'b0, 32'h0, 1'b1);
    send_word(64'hFFFFFFFFFFFFFFFF, 8'h00, 1'b0, 1'b1, ref_crc(b), 1'b1);
    wait_drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL keep_gap_drain: outstanding=%0d want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_sop_restart();
    bit ok;
    send_word(64'h5858585858585858, 8'hFF, 1'b1, 1'b0, 32'h0, 1'b1);
    send_word(64'h3837363534333231, 8'hFF, 1'b1, 1'b0, 32'h0, 1'b1);
    send_word(64'h0000000000000039, 8'h01, 1'b0, 1'b1, 32'hCBF43926, 1'b1);
    wait_drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL sop_restart_drain: outstanding=%0d want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_random();
    bit ok;
    int n, words, rem;
    logic [7:0]  b[$];
    logic [63:0] d;
    logic [7:0]  k;
    for (int p = 0; p < 8; p++) begin
      b.delete();
      n = $urandom_range(1, 24);
      for (int i = 0; i < n; i++) b.push_back(8'($urandom));
      words = (n + 7) / 8;
      rem = n - 8 * (words - 1);
      for (int w = 0; w < words; w++) begin
        for (int j = 0; j < 8; j++) d[8*j +: 8] = (8*w + j < n) ? b[8*w + j] : 8'($urandom);
        if (w == words - 1) begin
          for (int j = 0; j < 8; j++) k[j] = (j < rem) ? 1'b1 : ((j == rem) ? 1'b0 : 1'($urandom));
        end else begin
          k = 8'($urandom);
        end
        send_word(d, k, (w == 0), (w == words - 1), (w == words - 1) ? ref_crc(b) : 32'h0, 1'b1);
        if ($urandom_range(0, 3) == 0) idle_cycle(1'($urandom));
      end
    end
    wait_drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL random_drain: outstanding=%0d want 0", exp_q.size()); exp_q.delete(); end
  endtask

  initial begin
    test_reset_state();
    test_two_word();
    test_back_to_back();
    test_ce_stall();
    test_reset_mid();
    test_keep_gap();
    test_sop_restart();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/crc32_stream.md
Name: crc32_stream

Overview:
- Parametrised streaming CRC-32 generator, successor to the fixed 64-bit CRC engine.
- Processes DATA_BYTES bytes per cycle and computes a per-packet Ethernet CRC-32 (reflected poly 0xEDB88320).
- Packets are framed by sop/eop, and a byte-enable on the last word removes the need to pad input to the word width.
- Sits between packetiser and transmit framer; data, framing and keep are passed through, delay-matched to the CRC.

Parameters:
- DATA_BYTES, 8, bytes per input word (1..32; data width = 8*DATA_BYTES).
- CRC_INIT, 32'hFFFFFFFF, accumulator value at start of packet.
- CRC_XOROUT, 32'hFFFFFFFF, value XORed onto the final CRC.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- ce  in  1  clock enable; all state holds when low
- valid_in  in  1  input word valid
- sop_in  in  1  first word of packet (qualified by valid_in)
- eop_in  in  1  last word of packet (qualified by valid_in)
- keep_in  in  DATA_BYTES  byte enables, byte0 = data_in[7:0]; honoured only on eop
- data_in  in  8*DATA_BYTES  packet data; byte0 is transmitted first, LSB-first per byte
- valid_out  out  1  delayed valid_in
- sop_out  out  1  delayed sop_in
- eop_out  out  1  delayed eop_in
- keep_out  out  DATA_BYTES  delayed keep_in (unmodified)
- data_out  out  8*DATA_BYTES  delayed data_in
- crc_valid  out  1  high for one cycle, coincident with valid_out & eop_out
- crc  out  32  final packet CRC, held until the next crc_valid

Behaviour:
- Reset (rstn low, asynchronous):
  - All pipeline valid/sop/eop bits go to 0; crc_valid=0.
  - crc=0; data_out=0; keep_out=0.
  - Accumulator = CRC_INIT.
  - Takes effect mid-packet, discarding any in-flight packet.
- Latency:
  - Fixed 4 ce-qualified cycles from input to all outputs, independent of DATA_BYTES.
  - Stages: input register; per-word partial CRC; accumulator combine; output register.
- Throughput: one word per ce cycle; no backpressure.
- ce low: every register, including the accumulator, holds its value; latency is counted in ce cycles.
- Accumulator update on a valid word:
  - Start value is CRC_INIT if sop, else the running accumulator.
  - Process the N bytes of the word, byte0 first.
  - N = DATA_BYTES on non-eop words; keep_in is ignored on those words.
  - On eop, N = the number of contiguous ones in keep_in counting up from bit0. Bytes above the first zero are ignored (e.g. keep=0b0101 gives N=1).
  - N=0 on eop: crc is taken from the accumulator as-is.
- Final CRC: crc = accumulator ^ CRC_XOROUT. It is loaded into crc on the same cycle that crc_valid pulses.
- sop & eop on the same word: single-word packet.
- Word without sop after eop, or after reset: continues from the accumulator, which is CRC_INIT after reset or after any eop.
- sop mid-packet: restarts from CRC_INIT; the prior partial packet produces no crc_valid.
- Invalid words: they do not touch the accumulator. valid_out=0 on the corresponding output cycle, and sop_out/eop_out are forced to 0.

Decomposition:
- Package crc32_pkg holds:
  - CRC32_POLY_REFL = 32'hEDB88320
  - default CRC_INIT and CRC_XOROUT
  - function crc32_byte(crc, byte), the single-byte reflected update.
- Sub-module crc32_word_update (combinational): crc_in, data, nbytes → crc_out. It is an unrolled loop of crc32_byte over bytes 0..nbytes-1. The top level registers its inputs and outputs to meet timing.

Test Plan:
- "123456789", DATA_BYTES=8: word0 data=64'h3837363534333231, keep=FF, sop=1; word1 data=..39, keep=01, eop=1 → 4 cycles after word1: crc_valid=1, crc=32'hCBF43926, data_out/keep_out match the inputs.
- DATA_BYTES=16, single word "123456789" with sop=eop=1, keep=16'h01FF → crc=32'hCBF43926.
- Back-to-back single-word packets "a" (keep=01) then "abc" (keep=07) on consecutive cycles → crc=32'hE8B7BE43, then 32'h352441C2 on the next cycle.
- "123456789" with ce low for 3 cycles between word0 and word1, plus valid_in=0 bubbles → same crc=32'hCBF43926; crc_valid arrives 4 ce-cycles after word1.
- rstn low for 2 cycles after word0 of "123456789", then "a" sent → outputs 0 while in reset, no crc_valid for the aborted packet, then crc=32'hE8B7BE43.
- eop word "a?c" with keep=0101 → treated as 1 byte, crc=32'hE8B7BE43; eop with keep=0 after "a" (non-eop, DATA_BYTES=1) → crc=32'hE8B7BE43.
